// File: rtl/cpu_seq.sv
// cpu_seq: multi-cycle FETCH/DECODE/MEM/WB sequencer that owns the shared RAM port.
// Optional macro CPU_SEQ_PERF_EN adds cycle and retired-instruction counters.
`default_nettype none

`ifndef RAM_NONE
`define RAM_NONE  2'b00
`endif
`ifndef RAM_READ
`define RAM_READ  2'b01
`endif
`ifndef RAM_WRITE
`define RAM_WRITE 2'b10
`endif

module cpu_seq #(
   parameter int TIMEOUT = 255,
   parameter int AW      = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [1:0]    i_ram_action,
   input  logic [AW-1:0] i_ram_addr,
   input  logic [AW-1:0] i_pc,
   input  logic          i_halt,
   input  logic          i_mem_ack,
   input  logic [31:0]   i_mem_rdata,
   output logic          o_mem_req,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [31:0]   o_inst_word,
   output logic [31:0]   o_ld_data,
   output logic          o_ir_load,
   output logic          o_pc_en,
   output logic          o_wb_en,
   output logic          o_halted,
   output logic          o_bus_err,
   output logic [2:0]    o_state
`ifdef CPU_SEQ_PERF_EN
   ,
   output logic [31:0]   o_cyc_cnt,
   output logic [31:0]   o_ins_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   state_t          r_state;
   logic [TW-1:0]   r_to_cnt;
   logic [31:0]     r_inst_word;
   logic [31:0]     r_ld_data;
   logic            r_ir_load;
   logic            r_pc_en;
   logic            r_wb_en;
   logic            r_halted;
   logic            r_bus_err;

   logic            w_busy;
   logic            w_ram_rd;
   logic            w_ram_wr;
   logic            w_timeout;

   assign w_ram_rd  = (i_ram_action == `RAM_READ);
   assign w_ram_wr  = (i_ram_action == `RAM_WRITE);
   assign w_busy    = (r_state == S_FETCH) || (r_state == S_MEM);
   // Ack takes priority, so a late ack on the final allowed cycle still completes.
   assign w_timeout = (TIMEOUT != 0) && !i_mem_ack && (r_to_cnt == TW'(TIMEOUT - 1));

   assign o_mem_req   = w_busy;
   assign o_mem_we    = (r_state == S_MEM) && w_ram_wr;
   assign o_mem_addr  = (r_state == S_MEM)   ? i_ram_addr :
                        (r_state == S_FETCH) ? i_pc       : '0;
   assign o_inst_word = r_inst_word;
   assign o_ld_data   = r_ld_data;
   assign o_ir_load   = r_ir_load;
   assign o_pc_en     = r_pc_en;
   assign o_wb_en     = r_wb_en;
   assign o_halted    = r_halted;
   assign o_bus_err   = r_bus_err;
   assign o_state     = r_state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_to_cnt    <= '0;
         r_inst_word <= '0;
         r_ld_data   <= '0;
         r_ir_load   <= 1'b0;
         r_pc_en     <= 1'b0;
         r_wb_en     <= 1'b0;
         r_halted    <= 1'b0;
         r_bus_err   <= 1'b0;
      end else begin
         r_ir_load <= 1'b0;
         r_pc_en   <= 1'b0;
         r_wb_en   <= 1'b0;
         r_to_cnt  <= '0;
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (i_mem_ack) begin
                  r_inst_word <= i_mem_rdata;
                  r_ir_load   <= 1'b1;
                  r_state     <= S_DECODE;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_state   <= S_ERR;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_DECODE: begin
               // Reserved action code falls through here as a register-only op.
               if (w_ram_rd || w_ram_wr) begin
                  r_state <= S_MEM;
               end else begin
                  r_pc_en <= 1'b1;
                  r_wb_en <= 1'b1;
                  r_state <= S_WB;
               end
            end
            S_MEM: begin
               if (i_mem_ack) begin
                  if (w_ram_rd) begin
                     r_ld_data <= i_mem_rdata;
                  end
                  r_pc_en <= 1'b1;
                  r_wb_en <= !w_ram_wr;
                  r_state <= S_WB;
               end else if (w_timeout) begin
                  r_bus_err <= 1'b1;
                  r_state   <= S_ERR;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_WB: begin
               if (i_halt) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_HALT: begin
               if (!i_halt) begin
                  r_halted <= 1'b0;
                  r_state  <= S_FETCH;
               end
            end
            S_ERR: begin
               r_state <= S_ERR;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CPU_SEQ_PERF_EN
   logic [31:0] r_cyc_cnt;
   logic [31:0] r_ins_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cyc_cnt <= '0;
         r_ins_cnt <= '0;
      end else begin
         if ((r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_ERR)) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
         end
         if (r_pc_en) begin
            r_ins_cnt <= r_ins_cnt + 32'd1;
         end
      end
   end

   assign o_cyc_cnt = r_cyc_cnt;
   assign o_ins_cnt = r_ins_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: scoreboard bench for cpu_seq driving a cycle-stepped RAM model.
`default_nettype none

module tb_cpu_seq;

   localparam logic [1:0] A_NONE = 2'b00;
   localparam logic [1:0] A_RD   = 2'b01;
   localparam logic [1:0] A_WR   = 2'b10;
   localparam logic [1:0] A_RSV  = 2'b11;

   logic        clk;
   logic        rst_n;
   logic [1:0]  i_ram_action;
   logic [31:0] i_ram_addr;
   logic [31:0] i_pc;
   logic        i_halt;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_inst_word;
   logic [31:0] o_ld_data;
   logic        o_ir_load;
   logic        o_pc_en;
   logic        o_wb_en;
   logic        o_halted;
   logic        o_bus_err;
   logic [2:0]  o_state;
`ifdef CPU_SEQ_PERF_EN
   logic [31:0] o_cyc_cnt;
   logic [31:0] o_ins_cnt;
   logic [31:0] cyc0;
   logic [31:0] ins0;
`endif

   typedef struct packed {
      logic        wb;
      logic [31:0] ld;
   } wb_exp_t;

   logic [31:0] q_inst[$];
   wb_exp_t     q_wb[$];
   logic [31:0] model_ld;
   logic [31:0] mon_inst;
   wb_exp_t     mon_wb;

   int n_pass;
   int n_total;

   cpu_seq #(.TIMEOUT(4), .AW(32)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_ram_action (i_ram_action),
      .i_ram_addr   (i_ram_addr),
      .i_pc         (i_pc),
      .i_halt       (i_halt),
      .i_mem_ack    (i_mem_ack),
      .i_mem_rdata  (i_mem_rdata),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_inst_word  (o_inst_word),
      .o_ld_data    (o_ld_data),
      .o_ir_load    (o_ir_load),
      .o_pc_en      (o_pc_en),
      .o_wb_en      (o_wb_en),
      .o_halted     (o_halted),
      .o_bus_err    (o_bus_err),
      .o_state      (o_state)
`ifdef CPU_SEQ_PERF_EN
      ,
      .o_cyc_cnt    (o_cyc_cnt),
      .o_ins_cnt    (o_ins_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Strobes are popped against the scoreboard when the DUT raises them.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_ir_load) begin
            if (q_inst.size() == 0) check("ir_load_unexpected", 32'(o_ir_load), 32'd0);
            else begin
               mon_inst = q_inst.pop_front();
               check("inst_word", o_inst_word, mon_inst);
            end
         end
         if (o_pc_en) begin
            if (q_wb.size() == 0) check("pc_en_unexpected", 32'(o_pc_en), 32'd0);
            else begin
               mon_wb = q_wb.pop_front();
               check("wb_en", 32'(o_wb_en), 32'(mon_wb.wb));
               check("ld_data", o_ld_data, mon_wb.ld);
            end
         end else if (o_wb_en) begin
            check("wb_en_without_pc_en", 32'(o_wb_en), 32'd0);
         end
      end
   end

   // One RAM transaction: waits cycles with no ack, then ack with data.
   task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                        input int waits, input logic [31:0] data, input logic halt_mid);
      for (int k = 0; k <= waits; k++) begin
         if (halt_mid && k == 0) i_halt = 1'b1;
         i_mem_ack   = (k == waits);
         i_mem_rdata = (k == waits) ? data : 32'hBAD0_0000 + 32'(k);
         #1;
         check({tag, "_req"}, 32'(o_mem_req), 32'd1);
         check({tag, "_addr"}, o_mem_addr, addr);
         check({tag, "_we"}, 32'(o_mem_we), 32'(we));
         tick();
         i_mem_ack = 1'b0;
      end
   endtask

   task automatic do_instr(input logic [31:0] pc, input logic [1:0] act, input logic [31:0] addr,
                           input logic [31:0] inst, input logic [31:0] mdata,
                           input int fw, input int mw, input logic halt_mid);
      logic is_mem;
      i_pc         = pc;
      i_ram_action = act;
      i_ram_addr   = addr;
      is_mem       = (act == A_RD) || (act == A_WR);
      if (act == A_RD) model_ld = mdata;
      q_inst.push_back(inst);
      q_wb.push_back('{wb: (act != A_WR), ld: model_ld});
      check("fetch_state", 32'(o_state), 32'd1);
      serve("fetch", pc, 1'b0, fw, inst, 1'b0);
      check("decode_state", 32'(o_state), 32'd2);
      check("decode_req", 32'(o_mem_req), 32'd0);
      tick();
      if (is_mem) serve("mem", addr, act == A_WR, mw, mdata, halt_mid);
      check("wb_state", 32'(o_state), 32'd4);
      check("wb_req", 32'(o_mem_req), 32'd0);
      tick();
   endtask

   initial begin
      n_pass       = 0;
      n_total      = 0;
      model_ld     = 32'd0;
      rst_n        = 1'b0;
      i_ram_action = A_NONE;
      i_ram_addr   = 32'd0;
      i_pc         = 32'h10;
      i_halt       = 1'b0;
      i_mem_ack    = 1'b0;
      i_mem_rdata  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(o_state), 32'd0);
      check("rst_req", 32'(o_mem_req), 32'd0);
      check("rst_inst", o_inst_word, 32'd0);
      check("rst_ld", o_ld_data, 32'd0);
      check("rst_strobes", {29'd0, o_ir_load, o_pc_en, o_wb_en}, 32'd0);
      check("rst_halt_err", {30'd0, o_halted, o_bus_err}, 32'd0);

      // IDLE cycle with a stray ack that must be ignored.
      rst_n     = 1'b1;
      i_mem_ack = 1'b1;
      i_mem_rdata = 32'hFFFF_0000;
      #1;
      check("idle_state", 32'(o_state), 32'd0);
      check("idle_req", 32'(o_mem_req), 32'd0);
      tick();
      i_mem_ack = 1'b0;
      check("idle_ack_ignored", o_inst_word, 32'd0);

      do_instr(32'h10, A_NONE, 32'h0,   32'h1111_0001, 32'h0,         0, 0, 1'b0);
      do_instr(32'h14, A_RD,   32'h200, 32'h2222_0002, 32'hDEAD_BEEF, 0, 2, 1'b0);
      do_instr(32'h18, A_WR,   32'h300, 32'h3333_0003, 32'h0,         0, 0, 1'b0);
      do_instr(32'h1C, A_RSV,  32'h999, 32'h4444_0004, 32'h0,         0, 0, 1'b0);
      do_instr(32'h20, A_NONE, 32'h0,   32'h5555_0005, 32'h0,         3, 0, 1'b0);

      // Halt raised during MEM: instruction completes, then sequencer parks.
      do_instr(32'h24, A_RD,   32'h240, 32'h6666_0006, 32'hCAFE_F00D, 0, 1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         check("halt_state", 32'(o_state), 32'd5);
         check("halt_flag", 32'(o_halted), 32'd1);
         check("halt_req", 32'(o_mem_req), 32'd0);
         tick();
      end
      i_halt = 1'b0;
      tick();
      check("unhalt_state", 32'(o_state), 32'd1);
      check("unhalt_flag", 32'(o_halted), 32'd0);

`ifdef CPU_SEQ_PERF_EN
      cyc0 = o_cyc_cnt;
      ins0 = o_ins_cnt;
`endif
      for (int n = 0; n < 5; n++)
         do_instr(32'h30 + 32'(4 * n), A_NONE, 32'h0, 32'h7000_0000 + 32'(n), 32'h0, 0, 0, 1'b0);
`ifdef CPU_SEQ_PERF_EN
      check("perf_ins", o_ins_cnt - ins0, 32'd5);
      check("perf_cyc", o_cyc_cnt - cyc0, 32'd15);
`endif

      // Fetch that never acks: four request cycles, then sticky ERR.
      i_pc = 32'h40;
      for (int k = 0; k < 4; k++) begin
         check("to_fetch_state", 32'(o_state), 32'd1);
         check("to_req", 32'(o_mem_req), 32'd1);
         tick();
      end
      i_mem_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("err_state", 32'(o_state), 32'd6);
         check("err_flag", 32'(o_bus_err), 32'd1);
         check("err_req", 32'(o_mem_req), 32'd0);
         check("err_strobes", {29'd0, o_ir_load, o_pc_en, o_wb_en}, 32'd0);
         tick();
      end
      i_mem_ack = 1'b0;

      rst_n = 1'b0;
      #1;
      check("err_clear", 32'(o_bus_err), 32'd0);
      check("err_rst_state", 32'(o_state), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("refetch_state", 32'(o_state), 32'd1);

      // Reset in the middle of a fetch, with the late ack landing in IDLE.
      rst_n = 1'b0;
      #1;
      check("midrst_req", 32'(o_mem_req), 32'd0);
      tick();
      rst_n       = 1'b1;
      i_mem_ack   = 1'b1;
      i_mem_rdata = 32'h1234_5678;
      tick();
      i_mem_ack = 1'b0;
      check("midrst_fetch", 32'(o_state), 32'd1);
      check("midrst_inst", o_inst_word, 32'd0);
      check("midrst_ir_load", 32'(o_ir_load), 32'd0);

      check("scoreboard_empty", 32'(q_inst.size() + q_wb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
